// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader FSM states and byte-per-word constant.
package imem_loader_pkg;
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loaderState_t;
   localparam int LOADER_BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into instruction words and writes them to imem.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int INST_WIDTH      = 32,
   parameter int INST_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [INST_ADDR_WIDTH-2:0] loadLen,
   input  logic                       inValid,
   input  logic [7:0]                 inData,
   output logic                       inReady,
   output logic                       iMemW,
   output logic [INST_ADDR_WIDTH-1:0] iMemWAddr,
   output logic [INST_WIDTH-1:0]      iMemDataOut,
   output logic                       cpuHold,
   output logic                       done,
   output logic                       lenError,
   output logic [31:0]                checksum
);
   localparam int LW = INST_ADDR_WIDTH - 1;
   localparam int WB = INST_ADDR_WIDTH - 2;
   localparam int BW = $clog2(LOADER_BYTES_PER_WORD);
   localparam logic [LW-1:0] DEPTH = LW'(1 << WB);
   localparam logic [LW-1:0] ONE_L = LW'(1);
   localparam logic [BW-1:0] ONE_B = BW'(1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(LOADER_BYTES_PER_WORD - 1);

   loaderState_t state, nextState;
   logic [LW-1:0] lenReg, wordCnt;
   logic [BW-1:0] byteCnt;
   logic [INST_WIDTH-1:0] word;
   logic accept, startOk;

   assign accept      = inValid && inReady;
   assign startOk     = state == IDLE && start && loadLen <= DEPTH;
   assign inReady     = state == RECV;
   assign iMemW       = state == WRITE;
   assign done        = state == DONE;
   assign cpuHold     = state != IDLE;
   assign iMemWAddr   = {2'b00, wordCnt[WB-1:0]};
   assign iMemDataOut = word;

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:  if (startOk) nextState = loadLen == '0 ? DONE : RECV;
         RECV:  if (accept && byteCnt == LAST_BYTE) nextState = WRITE;
         WRITE: nextState = wordCnt + ONE_L == lenReg ? DONE : RECV;
         DONE:  nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         lenReg   <= '0;
         wordCnt  <= '0;
         byteCnt  <= '0;
         word     <= '0;
         checksum <= '0;
         lenError <= 1'b0;
      end else begin
         state <= nextState;
         if (state == IDLE && start && !startOk) lenError <= 1'b1;
         if (startOk) begin
            lenReg   <= loadLen;
            wordCnt  <= '0;
            byteCnt  <= '0;
            checksum <= '0;
            lenError <= 1'b0;
         end
         // byteCnt wraps to zero after the last byte of each word
         if (accept) begin
            word    <= {inData, word[INST_WIDTH-1:8]};
            byteCnt <= byteCnt + ONE_B;
         end
         if (state == WRITE) begin
            checksum <= checksum + word;
            wordCnt  <= wordCnt + ONE_L;
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader with a word-level reference model.
module tb_imem_loader;
   typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
   typedef struct {int cyc; logic [31:0] sum;} dn_t;

   logic clk = 0, rst = 0, start = 0, inValid = 0;
   logic [8:0] loadLen = '0;
   logic [7:0] inData = '0;
   logic inReady, iMemW, cpuHold, done, lenError;
   logic [9:0] iMemWAddr;
   logic [31:0] iMemDataOut, checksum;

   int tests = 0, fails = 0, cyc = 0, writeCount = 0;
   bit prevDone = 0;
   wr_t wq[$];
   dn_t dq[$];

   imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .loadLen(loadLen), .inValid(inValid),
      .inData(inData), .inReady(inReady), .iMemW(iMemW), .iMemWAddr(iMemWAddr),
      .iMemDataOut(iMemDataOut), .cpuHold(cpuHold), .done(done), .lenError(lenError),
      .checksum(checksum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected writes and done pulses as the DUT presents them
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (prevDone) begin
         chk("done_one_cycle", {31'b0, done}, 0);
         chk("hold_low_after_done", {31'b0, cpuHold}, 0);
      end
      prevDone = done;
      if (iMemW) begin
         writeCount++;
         chk("write_expected", {31'b0, wq.size() > 0}, 1);
         if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("write_addr", {22'b0, iMemWAddr}, w.addr);
            chk("write_data", iMemDataOut, w.data);
            if (w.cyc >= 0) chk("write_cycle", cyc, w.cyc);
         end
      end
      if (done) begin
         chk("done_expected", {31'b0, dq.size() > 0}, 1);
         chk("hold_in_done", {31'b0, cpuHold}, 1);
         if (dq.size() > 0) begin
            d = dq.pop_front();
            chk("checksum", checksum, d.sum);
            if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
         end
      end
   end

   function automatic int acceptCyc(input int c, input int j, input int stallAt, input int stallLen);
      return c + 1 + j + j / 4 + ((stallAt >= 0 && j >= stallAt) ? stallLen : 0);
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic feed(input logic [7:0] b[$], input int stallAt, input int stallLen);
      int n;
      bit acc;
      for (int i = 0; i < b.size(); i++) begin
         if (i == stallAt) begin
            inValid = 0;
            repeat (stallLen) begin
               @(negedge clk);
               chk("ready_during_stall", {31'b0, inReady}, 1);
               step();
            end
         end
         inValid = 1;
         inData = b[i];
         n = 0;
         acc = 0;
         while (!acc) begin
            @(negedge clk);
            acc = inReady;
            step();
            n++;
            if (n > 20 && !acc) begin
               chk("byte_accept_timeout", n, 0);
               inValid = 0;
               return;
            end
         end
      end
      inValid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((wq.size() > 0 || dq.size() > 0) && n < 3000) begin
         step();
         n++;
      end
      chk("drain_timeout", {31'b0, n >= 3000}, 0);
      step();
   endtask

   task automatic runLoad(input int len, input logic [31:0] w[$], input int stallAt, input int stallLen);
      logic [7:0] b[$];
      logic [31:0] sum;
      int c;
      sum = 0;
      b = {};
      c = cyc;
      for (int k = 0; k < len; k++) begin
         for (int j = 0; j < 4; j++) b.push_back(w[k][8*j +: 8]);
         wq.push_back('{k, w[k], acceptCyc(c, 4*k + 3, stallAt, stallLen) + 1});
         sum += w[k];
      end
      dq.push_back('{len == 0 ? c + 1 : acceptCyc(c, 4*len - 1, stallAt, stallLen) + 2, sum});
      loadLen = 9'(len);
      start = 1;
      step();
      start = 0;
      feed(b, stallAt, stallLen);
      drain();
   endtask

   initial begin
      logic [31:0] w[$];
      logic [7:0] b[$];
      int n, st, base;
      repeat (3) step();
      chk("rst_ready", {31'b0, inReady}, 0);
      chk("rst_w", {31'b0, iMemW}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_hold", {31'b0, cpuHold}, 0);
      chk("rst_lenerr", {31'b0, lenError}, 0);
      chk("rst_checksum", checksum, 0);
      rst = 1;
      step();

      // Two-word load, continuous and then stalled after byte 2
      runLoad(2, '{32'h00000013, 32'h00100093}, -1, 0);
      chk("checksum_pair", checksum, 32'h001000A6);
      runLoad(2, '{32'h00000013, 32'h00100093}, 2, 3);

      // Full depth, word i = i
      w = {};
      for (int i = 0; i < 256; i++) w.push_back(32'(i));
      runLoad(256, w, -1, 0);
      chk("checksum_full", checksum, 32'h00007F80);

      // Oversize length: flagged, no writes, core not held
      loadLen = 9'd300;
      start = 1;
      step();
      start = 0;
      repeat (4) begin
         @(negedge clk);
         chk("oversize_lenerr", {31'b0, lenError}, 1);
         chk("oversize_hold", {31'b0, cpuHold}, 0);
         step();
      end
      runLoad(1, '{$urandom}, -1, 0);
      chk("lenerr_cleared", {31'b0, lenError}, 0);

      runLoad(0, '{}, -1, 0);
      chk("checksum_empty", checksum, 0);

      // Randomized loads with mid-word stalls
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 8);
         w = {};
         for (int k = 0; k < n; k++) w.push_back($urandom);
         st = ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(0, n - 1) + $urandom_range(1, 3) : -1;
         runLoad(n, w, st, $urandom_range(1, 4));
      end

      // Reset after 6 bytes of a 4-word load; a mid-load start must be ignored
      w = {};
      b = {};
      for (int k = 0; k < 4; k++) w.push_back($urandom);
      for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) b.push_back(w[k][8*j +: 8]);
      wq.push_back('{0, w[0], -1});
      base = writeCount;
      loadLen = 9'd4;
      start = 1;
      step();
      start = 0;
      feed(b[0:1], -1, 0);
      loadLen = 9'd2;
      start = 1;
      step();
      start = 0;
      feed(b[2:5], -1, 0);
      rst = 0;
      #1;
      chk("abort_ready", {31'b0, inReady}, 0);
      chk("abort_w", {31'b0, iMemW}, 0);
      chk("abort_done", {31'b0, done}, 0);
      chk("abort_hold", {31'b0, cpuHold}, 0);
      chk("abort_lenerr", {31'b0, lenError}, 0);
      chk("abort_checksum", checksum, 0);
      repeat (3) step();
      rst = 1;
      repeat (5) step();
      chk("abort_write_count", writeCount - base, 1);

      chk("writes_left", wq.size(), 0);
      chk("dones_left", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter INST_WIDTH, default 32, instruction word width in bits; only 32 is supported.
REQ-002 The block SHALL have parameter INST_ADDR_WIDTH, default 10, instruction-memory byte-address width; depth is 1 << (INST_ADDR_WIDTH-2) words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 The block SHALL have port loadLen  input  INST_ADDR_WIDTH-1  number of words to load; sampled when start is accepted.
REQ-007 The block SHALL have port inValid  input  1  byte stream valid.
REQ-008 The block SHALL have port inData  input  8  byte stream data.
REQ-009 The block SHALL have port inReady  output  1  byte stream ready.
REQ-010 The block SHALL have port iMemW  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port iMemWAddr  output  INST_ADDR_WIDTH  word index, zero-extended in the upper two bits.
REQ-012 The block SHALL have port iMemDataOut  output  INST_WIDTH  word to write.
REQ-013 The block SHALL have port cpuHold  output  1  holds the core in reset while high.
REQ-014 The block SHALL have port done  output  1  one-cycle load-complete pulse.
REQ-015 The block SHALL have port lenError  output  1  sticky oversize-length flag.
REQ-016 The block SHALL have port checksum  output  32  mod-2^32 sum of the words written by the last load.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, start with 0 < loadLen <= depth SHALL do all of the following: latch loadLen; clear the byte counter, word counter and checksum; clear lenError; go to RECV.
REQ-019 In IDLE, start with loadLen == 0 SHALL go directly to DONE with no writes and checksum = 0.
REQ-020 In IDLE, start with loadLen > depth SHALL set lenError, perform no writes and stay in IDLE.
REQ-021 A byte SHALL be accepted only in a cycle where inValid and inReady are both 1.
REQ-022 inReady SHALL be 1 only in RECV.
REQ-023 Bytes SHALL be assembled little-endian: the first byte goes to bits 7:0 and the fourth byte to bits 31:24.
REQ-024 On acceptance of the fourth byte the FSM SHALL go to WRITE in the next cycle; inValid low stalls RECV indefinitely with no timeout.
REQ-025 In WRITE, iMemW SHALL be 1 for exactly one cycle, with iMemWAddr = {2'b00, word counter} and iMemDataOut = the assembled word.
REQ-026 In the same WRITE cycle the checksum SHALL add the word (mod 2^32) and the word counter SHALL increment.
REQ-027 From WRITE, the FSM SHALL go to DONE when the incremented count equals the latched length, otherwise back to RECV.
REQ-028 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 cpuHold SHALL be 1 in RECV, WRITE and DONE, and SHALL go low in the cycle after DONE.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 iMemW SHALL be 0 outside WRITE, and outside WRITE iMemWAddr and iMemDataOut SHALL be don't-care.
REQ-032 Load throughput SHALL be at most one word per 5 cycles: 4 accept cycles plus 1 write cycle.
REQ-033 The word counter SHALL NOT wrap: a length equal to depth writes word indices 0 to depth-1 exactly once.

Reset
REQ-034 When rst is low, the block SHALL immediately force the FSM to IDLE, all counters to 0, and inReady, iMemW, done, lenError, cpuHold and checksum to 0.
REQ-035 A reset in the middle of a load SHALL abandon the load without any further write; words already written remain in memory.

Structure
REQ-036 The FSM state enum and the LOADER_BYTES_PER_WORD = 4 constant SHALL live in the shared core package.
REQ-037 The block SHALL be a single module with no sub-modules; the byte assembler is an inline shift register.
REQ-038 At system level, cpuHold SHALL be ORed into the core's reset and iMemW/iMemWAddr/iMemDataOut SHALL drive the instruction memory's unused write port.

Verification
REQ-039 The bench SHALL cover: loadLen=2, bytes 13 00 00 00 93 00 10 00 with inValid always high -> writes (0,0x00000013) then (1,0x00100093), done on cycle 11 after start, checksum 0x001000A6.
REQ-040 The bench SHALL cover: the same stream with inValid low for 3 cycles after byte 2 -> identical writes delayed by 3 cycles, with inReady held high throughout the stall.
REQ-041 The bench SHALL cover: loadLen=256 with word i = i -> 256 writes to addresses 0..255, no wrap, checksum 0x00007F80.
REQ-042 The bench SHALL cover: loadLen=300 -> lenError=1, no iMemW, cpuHold stays 0; a subsequent valid start clears lenError.
REQ-043 The bench SHALL cover: loadLen=0 -> done one cycle after the DONE-entry edge, no writes, checksum 0.
REQ-044 The bench SHALL cover: rst low after 6 bytes of a 4-word load -> exactly 1 write observed, all outputs 0, and a start pulse issued during that load (before the reset) ignored.
